rom_load_ctrl: RTL and testbench
================================

Name: rom_load_ctrl

Overview:
- Owns the PRG and CHR game-ROM memory ports and sequences the NES core around ROM loading.
- While the SoC ROM programmer streams bytes (level-style wren strobes), it turns each strobe into exactly one write and holds the NES in reset.
- It detects end-of-load by write inactivity, holds reset for a settle period, then hands the ROM address ports to the CPU/PPU read paths.
- Sits between the SoC game-ROM conduit and the NES architecture's ROM instances, on the NES master clock.

Parameters:
- PRG_AW, 15, PRG ROM address width (32 KiB).
- CHR_AW, 13, CHR ROM address width (8 KiB).
- IDLE_TIMEOUT, 50000, consecutive cycles with no write edge in LOADING that end a load (>=2).
- RESET_HOLD, 64, cycles NES reset stays asserted in SETTLE (>=1).

Ports:
- Clk  in  1  NES master clock (MCLK)
- Reset_n  in  1  asynchronous active-low reset
- prgmr_addr  in  16  programmer byte address, synchronous to Clk
- prgmr_data  in  8  programmer byte data
- prg_wren_in  in  1  programmer PRG write strobe, level, may stay high many cycles
- chr_wren_in  in  1  programmer CHR write strobe, level
- ext_reset_h  in  1  synced pushbutton reset, active high
- cpu_addr  in  PRG_AW  CPU PRG read address
- ppu_addr  in  CHR_AW  PPU CHR read address
- prg_rom_addr  out  PRG_AW  PRG memory address
- prg_rom_data  out  8  PRG memory write data
- prg_rom_we  out  1  PRG memory write enable, single-cycle
- chr_rom_addr  out  CHR_AW  CHR memory address
- chr_rom_data  out  8  CHR memory write data
- chr_rom_we  out  1  CHR memory write enable, single-cycle
- nes_reset_h  out  1  NES CPU/PPU reset, active high
- loading  out  1  high in every state except RUN
- prg_count  out  16  PRG bytes written this load, saturating
- chr_count  out  16  CHR bytes written this load, saturating
- addr_err  out  1  sticky: write attempted with address out of range

Behaviour:
- Reset values: state=IDLE; all we=0; addr/data regs=0; counts=0; addr_err=0; loading=1; nes_reset_h=1.
- Edge detect: registered copies of each wren; write edge = wren_in & ~wren_q. The edge in cycle n registers addr/data and drives the matching we high in cycle n+1 for exactly one cycle. A held strobe produces no further writes.
- A PRG and CHR edge in the same cycle commit in the same cycle; the memories are independent.
- Range check: a PRG edge with prgmr_addr[15:PRG_AW]!=0 (CHR likewise) does not raise we, sets addr_err, and does not increment the count.
- Counts +1 per committed write; saturate at 16'hFFFF.
- States:
  - IDLE: wait. Any edge -> LOADING.
  - LOADING: idle counter clears on any edge and increments otherwise. At IDLE_TIMEOUT-1 -> SETTLE.
  - SETTLE: hold counter runs RESET_HOLD cycles -> RUN.
  - RUN: any edge -> LOADING.
- Entry into LOADING from IDLE or RUN clears prg_count, chr_count and addr_err in the same cycle the edge is registered. The triggering write still commits, so the count reads 1 afterwards.
- nes_reset_h = (state!=RUN) | ext_reset_h, from the registered state. ext_reset_h never changes the state.
- Address mux:
  - RUN: prg_rom_addr=cpu_addr, chr_rom_addr=ppu_addr (combinational).
  - Other states: the registered programmer address.
  - The data outputs always carry the registered programmer data.
- A write edge during SETTLE commits, returns to LOADING and restarts the idle counter. Counts are not cleared (same load).
- Reset_n low mid-load aborts immediately: any in-flight we drops, counts clear, and the next load starts from IDLE.

Test Plan:
- Reset, then PRG strobe high 5 cycles at addr 16'h0010, data 8'hA9 -> prg_rom_we high exactly 1 cycle, one cycle after the edge; prg_rom_addr=15'h0010, data=A9; prg_count=1; nes_reset_h=1.
- 3 PRG + 2 CHR writes, with one PRG and one CHR edge coincident, then silence with IDLE_TIMEOUT=100, RESET_HOLD=8 -> both we pulse together; counts 3/2; LOADING->SETTLE after 100 idle cycles; nes_reset_h falls 8 cycles later; loading=0.
- In RUN with cpu_addr=15'h7FFC -> prg_rom_addr=7FFC with no write. A new CHR edge -> loading=1 and nes_reset_h=1 the next cycle; chr_count=1, prg_count=0.
- CHR write at addr 16'h2000 -> chr_rom_we stays 0; addr_err=1 and sticky through RUN; cleared on the next load start.
- Write edge 3 cycles into SETTLE -> back to LOADING; counts keep accumulating; reset held until a full new timeout plus hold.
- Reset_n asserted one cycle after an edge -> no we pulse; state IDLE; counts 0. ext_reset_h pulse in RUN -> nes_reset_h follows it; state stays RUN.

Source files
------------

// File: rtl/rom_load_ctrl.sv
// ROM load sequencer: turns programmer wren strobes into single-cycle PRG/CHR writes,
// holds the NES in reset while loading, and hands the ROM ports to the CPU/PPU when done.
module rom_load_ctrl #(
  parameter int unsigned PRG_AW       = 15,
  parameter int unsigned CHR_AW       = 13,
  parameter int unsigned IDLE_TIMEOUT = 50000,
  parameter int unsigned RESET_HOLD   = 64
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [15:0]       prgmr_addr,
  input  logic [7:0]        prgmr_data,
  input  logic              prg_wren_in,
  input  logic              chr_wren_in,
  input  logic              ext_reset_h,
  input  logic [PRG_AW-1:0] cpu_addr,
  input  logic [CHR_AW-1:0] ppu_addr,
  output logic [PRG_AW-1:0] prg_rom_addr,
  output logic [7:0]        prg_rom_data,
  output logic              prg_rom_we,
  output logic [CHR_AW-1:0] chr_rom_addr,
  output logic [7:0]        chr_rom_data,
  output logic              chr_rom_we,
  output logic              nes_reset_h,
  output logic              loading,
  output logic [15:0]       prg_count,
  output logic [15:0]       chr_count,
  output logic              addr_err
);

  localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                prg_wren_q, chr_wren_q;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PRG_AW-1:0]   prg_addr_q, prg_addr_d;
  logic [CHR_AW-1:0]   chr_addr_q, chr_addr_d;
  logic [7:0]          prg_data_q, prg_data_d;
  logic [7:0]          chr_data_q, chr_data_d;
  logic                prg_we_q, prg_we_d;
  logic                chr_we_q, chr_we_d;
  logic [15:0]         prg_cnt_q, prg_cnt_d;
  logic [15:0]         chr_cnt_q, chr_cnt_d;
  logic                addr_err_q, addr_err_d;

  logic prg_edge, chr_edge, any_edge;
  logic prg_in_range, chr_in_range;
  logic prg_commit, chr_commit;
  logic start_load;
  logic [15:0] prg_cnt_base, chr_cnt_base;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      prg_wren_q <= 1'b0;
      chr_wren_q <= 1'b0;
      idle_cnt_q <= '0;
      hold_cnt_q <= '0;
      prg_addr_q <= '0;
      chr_addr_q <= '0;
      prg_data_q <= '0;
      chr_data_q <= '0;
      prg_we_q   <= 1'b0;
      chr_we_q   <= 1'b0;
      prg_cnt_q  <= '0;
      chr_cnt_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prg_wren_q <= prg_wren_in;
      chr_wren_q <= chr_wren_in;
      idle_cnt_q <= idle_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      prg_addr_q <= prg_addr_d;
      chr_addr_q <= chr_addr_d;
      prg_data_q <= prg_data_d;
      chr_data_q <= chr_data_d;
      prg_we_q   <= prg_we_d;
      chr_we_q   <= chr_we_d;
      prg_cnt_q  <= prg_cnt_d;
      chr_cnt_q  <= chr_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    hold_cnt_d = hold_cnt_q;

    prg_edge     = prg_wren_in & ~prg_wren_q;
    chr_edge     = chr_wren_in & ~chr_wren_q;
    any_edge     = prg_edge | chr_edge;
    prg_in_range = (prgmr_addr[15:PRG_AW] == '0);
    chr_in_range = (prgmr_addr[15:CHR_AW] == '0);
    prg_commit   = prg_edge & prg_in_range;
    chr_commit   = chr_edge & chr_in_range;
    start_load   = any_edge & ((state_q == ST_IDLE) | (state_q == ST_RUN));

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (any_edge) begin
          state_d    = ST_LOADING;
          idle_cnt_d = '0;
        end
      end
      ST_LOADING: begin
        if (any_edge) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          state_d    = ST_SETTLE;
          hold_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_SETTLE: begin
        // A late write means the programmer is not done: resume the same load.
        if (any_edge) begin
          state_d    = ST_LOADING;
          idle_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    prg_we_d   = prg_commit;
    chr_we_d   = chr_commit;
    prg_addr_d = prg_commit ? prgmr_addr[PRG_AW-1:0] : prg_addr_q;
    chr_addr_d = chr_commit ? prgmr_addr[CHR_AW-1:0] : chr_addr_q;
    prg_data_d = prg_commit ? prgmr_data : prg_data_q;
    chr_data_d = chr_commit ? prgmr_data : chr_data_q;

    // A new load clears stats in the same cycle its triggering write is counted.
    prg_cnt_base = start_load ? 16'd0 : prg_cnt_q;
    chr_cnt_base = start_load ? 16'd0 : chr_cnt_q;
    prg_cnt_d    = (prg_commit && prg_cnt_base != 16'hFFFF) ? prg_cnt_base + 16'd1 : prg_cnt_base;
    chr_cnt_d    = (chr_commit && chr_cnt_base != 16'hFFFF) ? chr_cnt_base + 16'd1 : chr_cnt_base;
    addr_err_d   = (start_load ? 1'b0 : addr_err_q)
                 | (prg_edge & ~prg_in_range)
                 | (chr_edge & ~chr_in_range);
  end

  assign prg_rom_addr = (state_q == ST_RUN) ? cpu_addr : prg_addr_q;
  assign chr_rom_addr = (state_q == ST_RUN) ? ppu_addr : chr_addr_q;
  assign prg_rom_data = prg_data_q;
  assign chr_rom_data = chr_data_q;
  assign prg_rom_we   = prg_we_q;
  assign chr_rom_we   = chr_we_q;
  assign nes_reset_h  = (state_q != ST_RUN) | ext_reset_h;
  assign loading      = (state_q != ST_RUN);
  assign prg_count    = prg_cnt_q;
  assign chr_count    = chr_cnt_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl with a short idle timeout and reset hold.
module tb_rom_load_ctrl;

  localparam int unsigned PRG_AW = 15;
  localparam int unsigned CHR_AW = 13;
  localparam int unsigned T_IDLE = 100;
  localparam int unsigned T_HOLD = 8;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [15:0]       prgmr_addr;
  logic [7:0]        prgmr_data;
  logic              prg_wren_in, chr_wren_in, ext_reset_h;
  logic [PRG_AW-1:0] cpu_addr;
  logic [CHR_AW-1:0] ppu_addr;
  logic [PRG_AW-1:0] prg_rom_addr;
  logic [7:0]        prg_rom_data;
  logic              prg_rom_we;
  logic [CHR_AW-1:0] chr_rom_addr;
  logic [7:0]        chr_rom_data;
  logic              chr_rom_we;
  logic              nes_reset_h, loading;
  logic [15:0]       prg_count, chr_count;
  logic              addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  rom_load_ctrl #(
    .PRG_AW(PRG_AW), .CHR_AW(CHR_AW), .IDLE_TIMEOUT(T_IDLE), .RESET_HOLD(T_HOLD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .prgmr_addr(prgmr_addr), .prgmr_data(prgmr_data),
    .prg_wren_in(prg_wren_in), .chr_wren_in(chr_wren_in), .ext_reset_h(ext_reset_h),
    .cpu_addr(cpu_addr), .ppu_addr(ppu_addr),
    .prg_rom_addr(prg_rom_addr), .prg_rom_data(prg_rom_data), .prg_rom_we(prg_rom_we),
    .chr_rom_addr(chr_rom_addr), .chr_rom_data(chr_rom_data), .chr_rom_we(chr_rom_we),
    .nes_reset_h(nes_reset_h), .loading(loading),
    .prg_count(prg_count), .chr_count(chr_count), .addr_err(addr_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Raise the selected strobes for one edge; returns just after the edge registers.
  task automatic wr(input logic p, input logic c, input logic [15:0] a, input logic [7:0] d);
    prgmr_addr  = a;
    prgmr_data  = d;
    prg_wren_in = p;
    chr_wren_in = c;
    cyc(1);
  endtask

  task automatic rel();
    prg_wren_in = 1'b0;
    chr_wren_in = 1'b0;
    cyc(1);
  endtask

  initial begin
    Reset_n = 1'b0; prgmr_addr = '0; prgmr_data = '0;
    prg_wren_in = 1'b0; chr_wren_in = 1'b0; ext_reset_h = 1'b0;
    cpu_addr = '0; ppu_addr = '0;
    cyc(2);
    chk("rst_loading", loading, 1);
    chk("rst_nes_reset", nes_reset_h, 1);
    chk("rst_prg_we", prg_rom_we, 0);
    chk("rst_chr_we", chr_rom_we, 0);
    chk("rst_prg_count", prg_count, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_prg_addr", prg_rom_addr, 0);
    Reset_n = 1'b1;
    cyc(1);

    // Held strobe: one write, one cycle after the edge
    wr(1'b1, 1'b0, 16'h0010, 8'hA9);
    chk("t1_prg_we", prg_rom_we, 1);
    chk("t1_prg_addr", prg_rom_addr, 32'h0010);
    chk("t1_prg_data", prg_rom_data, 32'hA9);
    chk("t1_prg_count", prg_count, 1);
    chk("t1_nes_reset", nes_reset_h, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("t1_held_we", prg_rom_we, 0);
    end
    rel();

    // Mixed writes with one coincident PRG/CHR edge
    wr(1'b1, 1'b0, 16'h0011, 8'h5A);
    chk("t2_prg_we", prg_rom_we, 1);
    chk("t2_chr_we_quiet", chr_rom_we, 0);
    rel();
    wr(1'b1, 1'b1, 16'h0005, 8'h77);
    chk("t2_both_prg_we", prg_rom_we, 1);
    chk("t2_both_chr_we", chr_rom_we, 1);
    chk("t2_chr_addr", chr_rom_addr, 32'h0005);
    chk("t2_chr_data", chr_rom_data, 32'h77);
    rel();
    wr(1'b0, 1'b1, 16'h1FFF, 8'hE1);
    chk("t2_chr_top_we", chr_rom_we, 1);
    chk("t2_chr_top_addr", chr_rom_addr, 32'h1FFF);
    chk("t2_prg_count", prg_count, 3);
    chk("t2_chr_count", chr_count, 2);
    rel();
    cyc(T_IDLE - 2);
    chk("t2_still_loading", loading, 1);
    cyc(T_HOLD);
    chk("t2_hold_last", nes_reset_h, 1);
    cyc(1);
    chk("t2_run_nes_reset", nes_reset_h, 0);
    chk("t2_run_loading", loading, 0);
    chk("t2_run_prg_count", prg_count, 3);

    // RUN address mux, then a new load
    cpu_addr = 15'h7FFC; ppu_addr = 13'h0ABC;
    #1;
    chk("t3_cpu_mux", prg_rom_addr, 32'h7FFC);
    chk("t3_ppu_mux", chr_rom_addr, 32'h0ABC);
    chk("t3_no_we", prg_rom_we, 0);
    wr(1'b0, 1'b1, 16'h0100, 8'h42);
    chk("t3_loading", loading, 1);
    chk("t3_nes_reset", nes_reset_h, 1);
    chk("t3_chr_count", chr_count, 1);
    chk("t3_prg_count", prg_count, 0);
    chk("t3_chr_addr", chr_rom_addr, 32'h0100);
    rel();

    // Out-of-range CHR address
    wr(1'b0, 1'b1, 16'h2000, 8'h33);
    chk("t4_chr_we_blocked", chr_rom_we, 0);
    chk("t4_addr_err", addr_err, 1);
    chk("t4_chr_count", chr_count, 1);
    rel();
    cyc(T_IDLE + T_HOLD - 1);
    chk("t4_run", loading, 0);
    chk("t4_err_sticky", addr_err, 1);
    wr(1'b1, 1'b0, 16'h0000, 8'h11);
    chk("t4_err_cleared", addr_err, 0);
    chk("t4_new_prg_count", prg_count, 1);
    chk("t4_new_chr_count", chr_count, 0);
    rel();

    // Write 3 cycles into SETTLE resumes the load
    cyc(T_IDLE + 2);
    chk("t5_in_settle", nes_reset_h, 1);
    wr(1'b1, 1'b0, 16'h0001, 8'h22);
    chk("t5_prg_we", prg_rom_we, 1);
    chk("t5_prg_count", prg_count, 2);
    rel();
    cyc(T_IDLE + T_HOLD - 2);
    chk("t5_reset_held", nes_reset_h, 1);
    cyc(1);
    chk("t5_run", nes_reset_h, 0);

    // ext_reset_h in RUN, then async abort
    ext_reset_h = 1'b1;
    #1;
    chk("t6_ext_reset", nes_reset_h, 1);
    chk("t6_ext_state_run", loading, 0);
    cyc(2);
    chk("t6_ext_hold", nes_reset_h, 1);
    ext_reset_h = 1'b0;
    #1;
    chk("t6_ext_release", nes_reset_h, 0);
    wr(1'b0, 1'b1, 16'h0200, 8'h55);
    chk("t6_chr_we", chr_rom_we, 1);
    Reset_n = 1'b0;
    chr_wren_in = 1'b0;
    #1;
    chk("t6_abort_we", chr_rom_we, 0);
    chk("t6_abort_chr_count", chr_count, 0);
    chk("t6_abort_loading", loading, 1);
    cyc(1);
    Reset_n = 1'b1;
    cyc(T_IDLE + T_HOLD + 12);
    chk("t6_idle_no_run", nes_reset_h, 1);
    chk("t6_idle_loading", loading, 1);
    wr(1'b1, 1'b0, 16'h0003, 8'h99);
    chk("t6_reload_we", prg_rom_we, 1);
    chk("t6_reload_count", prg_count, 1);
    rel();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
